// File: rtl/rotate_pkg.sv
// -----------------------------------------------------------------------------
// rotate_pkg
// Shared constants and types for the 16-bit rotator front-ends.
//   WIDTH / AMT_W : data word width and rotate-amount width
//   CMD_W         : width of one packed rotate command
//   rot_dir_e     : rotate direction encoding (ROT_R = 0, ROT_L = 1)
//   rot_cmd_t     : packed command {lr, amt, data}
// -----------------------------------------------------------------------------
package rotate_pkg;

  localparam int WIDTH = 16;
  localparam int AMT_W = 4;
  localparam int CMD_W = WIDTH + AMT_W + 1;

  typedef enum logic {
    ROT_R = 1'b0,
    ROT_L = 1'b1
  } rot_dir_e;

  typedef struct packed {
    rot_dir_e           lr;
    logic [AMT_W-1:0]   amt;
    logic [WIDTH-1:0]   data;
  } rot_cmd_t;

endpackage

// File: rtl/rotate_cmd_unit_if.sv
// -----------------------------------------------------------------------------
// rotate_cmd_unit_if
// Command-in / result-out handshake bundle of rotate_cmd_unit.
//   in_valid/in_ready/in_data/in_amt/in_lr : command port (valid/ready)
//   out_valid/out_ready/out_data           : result port (valid/ready)
//   level                                  : command FIFO occupancy
// Modports: master = producer/consumer side, slave = the rotate unit.
// -----------------------------------------------------------------------------
interface rotate_cmd_unit_if #(
  parameter int DEPTH = 4
);

  localparam int LVL_W = $clog2(DEPTH + 1);

  logic                           in_valid;
  logic                           in_ready;
  logic [rotate_pkg::WIDTH-1:0]   in_data;
  logic [rotate_pkg::AMT_W-1:0]   in_amt;
  logic                           in_lr;
  logic                           out_valid;
  logic                           out_ready;
  logic [rotate_pkg::WIDTH-1:0]   out_data;
  logic [LVL_W-1:0]               level;

  modport master (
    output in_valid, in_data, in_amt, in_lr, out_ready,
    input  in_ready, out_valid, out_data, level
  );

  modport slave (
    input  in_valid, in_data, in_amt, in_lr, out_ready,
    output in_ready, out_valid, out_data, level
  );

endinterface

// File: rtl/multifunction_shifter_16.sv
// -----------------------------------------------------------------------------
// multifunction_shifter_16
// Combinational 16-bit rotator.
//   a_i   : input word
//   amt_i : rotate amount 0..15
//   lr_i  : 0 = rotate right, 1 = rotate left
//   y_o   : rotated word (pure bit permutation of a_i)
// -----------------------------------------------------------------------------
module multifunction_shifter_16 (
  input  logic [15:0] a_i,
  input  logic [3:0]  amt_i,
  input  logic        lr_i,
  output logic [15:0] y_o
);

  logic [31:0] dbl;

  // Shifting a doubled copy of the word makes the wrapped bits fall into
  // the half that is kept, so one shifter serves both directions.
  always_comb begin
    if (lr_i) begin
      dbl = {a_i, a_i} << amt_i;
      y_o = dbl[31:16];
    end else begin
      dbl = {a_i, a_i} >> amt_i;
      y_o = dbl[15:0];
    end
  end

endmodule

// File: rtl/rot_cmd_fifo.sv
// -----------------------------------------------------------------------------
// rot_cmd_fifo
// Parameterised synchronous FIFO for shifter front-ends.
//   clk, rst_n : clock, synchronous active-low reset
//   push_i     : write wdata_i (caller guarantees !full_o)
//   pop_i      : advance read pointer (caller guarantees !empty_o)
//   rdata_o    : current head entry (first-word fall-through)
//   full_o     : level_o == DEPTH
//   empty_o    : level_o == 0
//   level_o    : current occupancy 0..DEPTH
// DEPTH must be a power of two so pointers wrap naturally.
// -----------------------------------------------------------------------------
module rot_cmd_fifo #(
  parameter  int DATA_W = 8,
  parameter  int DEPTH  = 4,
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int LVL_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              full_o,
  output logic              empty_o,
  output logic [LVL_W-1:0]  level_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;

  // NOTE: the payload array has no reset; occupancy is tracked by level_q,
  // so stale entries are never observed and the array maps to plain storage.
  always_ff @(posedge clk) begin
    if (push_i) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_i, pop_i})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign full_o  = (level_q == LVL_W'(DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;

endmodule

// File: rtl/rotate_cmd_unit.sv
// -----------------------------------------------------------------------------
// rotate_cmd_unit
// Buffered, handshaked front-end for multifunction_shifter_16. Commands are
// queued in rot_cmd_fifo; the FIFO head feeds the rotator and the result is
// registered into a valid/ready output stage.
//   clk   : single clock
//   rst_n : synchronous active-low reset
//   bus   : rotate_cmd_unit_if.slave (command port, result port, level)
// -----------------------------------------------------------------------------
module rotate_cmd_unit
  import rotate_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  rotate_cmd_unit_if.slave   bus
);

  rot_cmd_t           push_cmd;
  rot_cmd_t           head_cmd;
  logic               fifo_full;
  logic               fifo_empty;
  logic               push;
  logic               load;
  logic [WIDTH-1:0]   rot_y;

  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   out_data_q,  out_data_d;

  assign push_cmd.lr   = rot_dir_e'(bus.in_lr);
  assign push_cmd.amt  = bus.in_amt;
  assign push_cmd.data = bus.in_data;

  // A full FIFO refuses commands even when a pop happens this cycle, and the
  // port is held off while reset is asserted.
  assign bus.in_ready = !fifo_full && rst_n;
  assign push         = bus.in_valid && bus.in_ready;

  // The output register accepts a new result when empty or being drained.
  assign load = !fifo_empty && (!out_valid_q || bus.out_ready);

  rot_cmd_fifo #(
    .DATA_W (CMD_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .wdata_i (push_cmd),
    .pop_i   (load),
    .rdata_o (head_cmd),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (bus.level)
  );

  multifunction_shifter_16 u_rot (
    .a_i   (head_cmd.data),
    .amt_i (head_cmd.amt),
    .lr_i  (head_cmd.lr),
    .y_o   (rot_y)
  );

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (load) begin
      out_valid_d = 1'b1;
      out_data_d  = rot_y;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;

endmodule

// File: tb/tb_rotate_cmd_unit.sv
// -----------------------------------------------------------------------------
// tb_rotate_cmd_unit
// Self-checking bench for rotate_cmd_unit: a queue-based reference model is
// compared against the DUT on every falling edge, and directed sequences pin
// literal results, latency, backpressure, push/pop and reset behaviour.
// -----------------------------------------------------------------------------
module tb_rotate_cmd_unit;

  localparam int DEPTH = 4;

  typedef struct {
    logic [15:0] data;
    logic [3:0]  amt;
    logic        lr;
  } cmd_s;

  logic clk;
  logic rst_n;

  rotate_cmd_unit_if #(.DEPTH(DEPTH)) bus ();

  rotate_cmd_unit #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Reference rotation from plain integer arithmetic.
  function automatic logic [15:0] rot_ref(input logic [15:0] a, input logic [3:0] n, input logic left);
    int ai, ni, r;
    ai = a;
    ni = n;
    if (left) r = (ai << ni) | (ai >> (16 - ni));
    else      r = (ai >> ni) | (ai << (16 - ni));
    return r[15:0];
  endfunction

  // ---------------------------------------------------------------- model
  cmd_s mq[$];
  bit   m_ov;
  int   m_od;
  bit   m_live = 1'b0;

  task automatic model_step();
    bit   acc, ld;
    cmd_s c;
    if (!rst_n) begin
      mq.delete();
      m_ov   = 1'b0;
      m_od   = 0;
      m_live = 1'b1;
    end else if (m_live) begin
      acc = bus.in_valid && (mq.size() < DEPTH);
      ld  = (mq.size() > 0) && (!m_ov || bus.out_ready);
      if (ld) begin
        m_od = rot_ref(mq[0].data, mq[0].amt, mq[0].lr);
        void'(mq.pop_front());
        m_ov = 1'b1;
      end else if (m_ov && bus.out_ready) begin
        m_ov = 1'b0;
      end
      if (acc) begin
        c.data = bus.in_data;
        c.amt  = bus.in_amt;
        c.lr   = bus.in_lr;
        mq.push_back(c);
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (m_live) begin
      check("out_valid", bus.out_valid, m_ov);
      check("out_data",  bus.out_data,  m_od & 'hFFFF);
      check("level",     bus.level,     mq.size());
      check("in_ready",  bus.in_ready,  rst_n && (mq.size() < DEPTH));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------- stimulus
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [15:0] d, input logic [3:0] a, input logic l);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_amt   = a;
    bus.in_lr    = l;
  endtask

  task automatic drain();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (8) tick();
  endtask

  task automatic single(input string nm, input logic [15:0] d, input logic [3:0] a,
                        input logic l, input logic [15:0] exp);
    check({nm, " in_ready"}, bus.in_ready, 1'b1);
    present(d, a, l);
    tick();
    bus.in_valid = 1'b0;
    check({nm, " not_early"}, bus.out_valid, 1'b0);
    tick();
    check({nm, " valid"}, bus.out_valid, 1'b1);
    check({nm, " data"},  bus.out_data,  exp);
    tick();
  endtask

  initial begin
    cmd_s        bp[6];
    int          idx, acc;
    bit          took;
    logic [15:0] held;

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_amt    = '0;
    bus.in_lr     = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) tick();
    check("rst out_valid", bus.out_valid, 1'b0);
    check("rst out_data",  bus.out_data,  16'h0000);
    check("rst level",     bus.level,     3'd0);
    check("rst in_ready",  bus.in_ready,  1'b0);
    rst_n = 1'b1;
    #1;
    check("post-rst in_ready", bus.in_ready, 1'b1);
    tick();

    // Single commands, literal results, two-edge latency.
    single("r1",  16'hB3CD, 4'd1, 1'b0, 16'hD9E6);
    single("r4",  16'hB3CD, 4'd4, 1'b0, 16'hDB3C);
    single("l1",  16'hB3CD, 4'd1, 1'b1, 16'h679B);
    single("l7",  16'hE3AA, 4'd7, 1'b1, 16'hD571);
    single("r0",  16'h0F0F, 4'd0, 1'b0, 16'h0F0F);
    single("l0",  16'hF0F0, 4'd0, 1'b1, 16'hF0F0);
    drain();

    // Backpressure: 6 commands offered with out_ready low, 5 accepted.
    for (int i = 0; i < 6; i++) begin
      bp[i].data = 16'($urandom);
      bp[i].amt  = 4'($urandom);
      bp[i].lr   = 1'($urandom);
    end
    bus.out_ready = 1'b0;
    idx  = 0;
    acc  = 0;
    held = '0;
    for (int c = 0; c < 8; c++) begin
      if (idx < 6) present(bp[idx].data, bp[idx].amt, bp[idx].lr);
      else         bus.in_valid = 1'b0;
      took = bus.in_valid && bus.in_ready;
      tick();
      if (took) begin
        acc++;
        idx++;
      end
      if (c == 1) held = bus.out_data;
    end
    bus.in_valid = 1'b0;
    check("bp accepted",  acc,           5);
    check("bp level",     bus.level,     3'd4);
    check("bp in_ready",  bus.in_ready,  1'b0);
    check("bp out_valid", bus.out_valid, 1'b1);
    check("bp stable",    bus.out_data,  held);
    check("bp res0",      bus.out_data,  rot_ref(bp[0].data, bp[0].amt, bp[0].lr));
    bus.out_ready = 1'b1;
    for (int k = 1; k < 5; k++) begin
      tick();
      check("bp drain valid", bus.out_valid, 1'b1);
      check("bp drain data",  bus.out_data,  rot_ref(bp[k].data, bp[k].amt, bp[k].lr));
    end
    tick();
    check("bp drained", bus.out_valid, 1'b0);
    drain();

    // Simultaneous push/pop with level = 2.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      present(16'h1111 * 16'(i + 1), 4'(i + 2), 1'(i));
      tick();
    end
    bus.in_valid = 1'b0;
    check("pp level before", bus.level, 3'd2);
    bus.out_ready = 1'b1;
    present(16'hA5C3, 4'd9, 1'b0);
    tick();
    bus.in_valid = 1'b0;
    check("pp level after", bus.level,    3'd2);
    check("pp head order",  bus.out_data, rot_ref(16'h2222, 4'd3, 1'b1));
    tick();
    check("pp order 2", bus.out_data, rot_ref(16'h3333, 4'd4, 1'b0));
    tick();
    check("pp order 3", bus.out_data, rot_ref(16'hA5C3, 4'd9, 1'b0));
    drain();

    // Pointer wrap-around: 10 back-to-back commands at full throughput.
    for (int i = 0; i < 10; i++) begin
      present(16'($urandom), 4'($urandom), 1'($urandom));
      tick();
      if (i > 0) check("wrap throughput", bus.out_valid, 1'b1);
    end
    drain();
    check("wrap level", bus.level, 3'd0);

    // Randomised traffic with random backpressure.
    for (int i = 0; i < 500; i++) begin
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.in_data   = 16'($urandom);
      bus.in_amt    = 4'($urandom);
      bus.in_lr     = 1'($urandom);
      bus.out_ready = ($urandom_range(0, 2) != 0);
      tick();
    end
    drain();

    // Reset mid-operation with level = 3 and a pending result.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      present(16'($urandom), 4'($urandom), 1'($urandom));
      tick();
    end
    bus.in_valid = 1'b0;
    check("mid level",     bus.level,     3'd3);
    check("mid out_valid", bus.out_valid, 1'b1);
    rst_n = 1'b0;
    tick();
    check("mid rst out_valid", bus.out_valid, 1'b0);
    check("mid rst level",     bus.level,     3'd0);
    check("mid rst in_ready",  bus.in_ready,  1'b0);
    rst_n = 1'b1;
    #1;
    check("mid rel in_ready", bus.in_ready, 1'b1);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("no stale result", bus.out_valid, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rotate_cmd_unit.md
# rotate_cmd_unit

Buffered, handshaked front-end for the 16-bit multifunction rotator. It accepts rotate commands (word, amount, direction) through a valid/ready port and queues them in a small FIFO. It presents the FIFO head to an instantiated `multifunction_shifter_16` and registers the result into a valid/ready output stage. The block sits between command producers and downstream consumers, decoupling both sides from the combinational rotator.

## Interface
- `WIDTH`, 16: data word width; fixed by the rotator instance.
- `AMT_W`, 4: rotate-amount width, log2(`WIDTH`).
- `DEPTH`, 4: command FIFO entries; power of two, at least 2.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `in_valid`  in  1  command present.
- `in_ready`  out  1  FIFO can accept a command.
- `in_data`  in  `WIDTH`  word to rotate.
- `in_amt`  in  `AMT_W`  rotate amount, 0..`WIDTH`-1.
- `in_lr`  in  1  0 = rotate right, 1 = rotate left.
- `out_valid`  out  1  result register holds a result.
- `out_ready`  in  1  consumer accepts the result.
- `out_data`  out  `WIDTH`  rotated word.
- `level`  out  clog2(`DEPTH`+1)  current FIFO occupancy.

## Operation
- Push when `in_valid && in_ready`. Command {data, amt, lr} is written at `wr_ptr`, and `wr_ptr` increments modulo `DEPTH`.
- `in_ready` = (`level` < `DEPTH`) && `rst_n`. A full FIFO deasserts `in_ready` even if a pop occurs in the same cycle; there is no full-bypass.
- The FIFO head (`rd_ptr` entry) drives the rotator continuously. `head_valid` = (`level` != 0).
- Output register load condition: `head_valid && (!out_valid || out_ready)`.
  - On load: `out_data` takes the rotator output, `out_valid` is set to 1, and the head is popped (`rd_ptr` increments modulo `DEPTH`).
- If `out_valid && out_ready` and nothing loads, `out_valid` clears. `out_data` holds its last value.
- `out_data` and `out_valid` stay stable while `out_valid && !out_ready`.
- Push and pop in the same cycle leave `level` unchanged; both pointers advance.
- Pop on empty and push on full are impossible by construction.
- Rotation semantics:
  - y = rotr(a, amt) when lr = 0; y = rotl(a, amt) when lr = 1.
  - amt = 0 passes the word unchanged.
  - No bits are lost; the rotation is a pure permutation.

## Timing
- Reset values: `out_valid` = 0, `out_data` = 0, `level` = 0, `wr_ptr` = `rd_ptr` = 0, `in_ready` = 0 while `rst_n` = 0.
- `in_ready` returns to 1 in the first cycle with `rst_n` = 1.
- Reset mid-operation discards all queued commands and any pending result. Stored FIFO payloads need not be cleared.
- Latency: a command accepted at edge N with an idle pipeline produces `out_valid` = 1 in the cycle after edge N+1 (two edges).
- Throughput: one command per cycle sustained when `out_ready` is held at 1.
- Backpressure: with `out_ready` = 0, the FIFO fills. `in_ready` drops after `DEPTH` further accepts beyond the one held in the output register.
- The output register and FIFO together hold at most `DEPTH`+1 commands in flight.
- `level` is registered and updates one edge after a push or pop.
- The rotator path is combinational head-to-output-register; it must close timing within one `clk` period.

## Structure
- The shared package/header `rotate_pkg` carries:
  - `WIDTH` and `AMT_W` constants;
  - the command field packing {lr, amt, data} with width `WIDTH`+`AMT_W`+1;
  - the direction encodings ROT_R = 0 and ROT_L = 1.
- Sub-module `rot_cmd_fifo`: a parameterised synchronous FIFO (pointers, `level`, full/empty). It is reusable by other shifter front-ends.
- Instantiates the existing `multifunction_shifter_16` unchanged. The output register and its handshake stay in the top module.

## Test plan
- Reset, then single commands with `out_ready` = 1:
  - 0xB3CD, amt 1, right → 0xD9E6;
  - 0xB3CD, amt 4, right → 0xDB3C;
  - 0xB3CD, amt 1, left → 0x679B;
  - 0xE3AA, amt 7, left → 0xD571.
  - Each result must arrive exactly two edges after acceptance.
- amt 0, both directions: 0x0F0F right → 0x0F0F; 0xF0F0 left → 0xF0F0.
- Backpressure:
  - Hold `out_ready` = 0 and stream 6 commands with `in_valid` = 1. Exactly 5 are accepted (1 in the output register, 4 in the FIFO), `level` reaches 4, `in_ready` = 0, and `out_data` stays stable.
  - Release `out_ready`: all 5 results emerge in order, one per cycle.
- Simultaneous push/pop at `level` = 2: `level` stays 2 and order is preserved. Pointer wrap-around is verified by 10 back-to-back commands.
- Reset asserted with `level` = 3 and `out_valid` = 1: the next cycle shows `out_valid` = 0, `level` = 0, `in_ready` = 0. After release, `in_ready` = 1 and no stale result appears.
